// File: rtl/csd_pkg.sv
// Shared definitions for the CSD/ASD converter and its shift-add multiplier consumer.
package csd_pkg;

    localparam int DW_DEF = 8;
    localparam int KW_DEF = 4;
    localparam int NT_DEF = 16;

    localparam logic [7:0] DIG_POS  = 8'h01;
    localparam logic [7:0] DIG_NEG  = 8'hFF;
    localparam logic [7:0] DIG_ZERO = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ACC,
        FIN
    } state_e;

    // Wide enough for a full DW-bit operand shifted by the largest k, plus a sign bit.
    function automatic int calc_pw(input int dw, input int kw);
        return dw + (2 ** kw) + 1;
    endfunction

    localparam int PW_DEF = calc_pw(DW_DEF, KW_DEF);

endpackage

// File: rtl/csd_term_alu.sv
// One CSD term step: acc +/- (x <<< k), flagging digits outside {+1, 0, -1}.
module csd_term_alu
    import csd_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int KW = KW_DEF,
    parameter int PW = calc_pw(DW, KW)
) (
    input  logic signed [PW-1:0] acc_i,
    input  logic signed [DW-1:0] x_i,
    input  logic        [DW-1:0] digit_i,
    input  logic        [KW-1:0] k_i,
    output logic signed [PW-1:0] acc_o,
    output logic                 illegal_o
);

    localparam logic [DW-1:0] D_POS  = DW'(DIG_POS);
    localparam logic [DW-1:0] D_NEG  = DW'($signed(DIG_NEG));
    localparam logic [DW-1:0] D_ZERO = DW'(DIG_ZERO);

    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] term;

    assign x_ext = {{(PW-DW){x_i[DW-1]}}, x_i};
    assign term  = x_ext <<< k_i;

    always_comb begin
        acc_o     = acc_i;
        illegal_o = 1'b0;
        if (digit_i == D_POS) begin
            acc_o = acc_i + term;
        end else if (digit_i == D_NEG) begin
            acc_o = acc_i - term;
        end else if (digit_i != D_ZERO) begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/csd_shift_add_mult.sv
// Start/done coprocessor multiplying x by a CSD constant read term-by-term from converter memory.
module csd_shift_add_mult
    import csd_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int KW = KW_DEF,
    parameter int NT = NT_DEF,
    parameter int PW = calc_pw(DW, KW),
    localparam int AW = $clog2(NT),
    localparam int CW = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [DW-1:0] x,
    input  logic        [CW-1:0] nTerms,
    output logic                 rdEn,
    output logic        [AW-1:0] rdAddr,
    input  logic        [DW-1:0] rdDigit,
    input  logic        [KW-1:0] rdK,
    output logic                 busy,
    output logic                 done,
    output logic signed [PW-1:0] product,
    output logic                 err
);

    state_e               state_q, state_d;
    logic signed [DW-1:0] x_q, x_d;
    logic        [CW-1:0] n_q, n_d;
    logic        [CW-1:0] idx_q, idx_d;
    logic signed [PW-1:0] acc_q, acc_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic                 err_q, err_d;
    logic        [AW-1:0] addr_q;
    logic signed [PW-1:0] alu_acc;
    logic                 alu_illegal;

    csd_term_alu #(
        .DW(DW),
        .KW(KW),
        .PW(PW)
    ) u_alu (
        .acc_i    (acc_q),
        .x_i      (x_q),
        .digit_i  (rdDigit),
        .k_i      (rdK),
        .acc_o    (alu_acc),
        .illegal_o(alu_illegal)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        n_d     = n_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    n_d     = (nTerms > CW'(NT)) ? CW'(NT) : nTerms;
                    acc_d   = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = (nTerms == '0) ? FIN : FETCH;
                end
            end
            FETCH: state_d = ACC;
            ACC: begin
                acc_d   = alu_acc;
                err_d   = err_q | alu_illegal;
                idx_d   = idx_q + CW'(1);
                state_d = (idx_q + CW'(1) == n_q) ? FIN : FETCH;
            end
            FIN: begin
                prod_d  = acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            addr_q  <= rdAddr;
        end
    end

    // Product is forwarded from acc during the done cycle so it is valid alongside done.
    assign rdEn    = (state_q == FETCH);
    assign rdAddr  = rdEn ? idx_q[AW-1:0] : addr_q;
    assign busy    = (state_q == FETCH) || (state_q == ACC);
    assign done    = (state_q == FIN);
    assign product = done ? acc_q : prod_q;
    assign err     = err_q;

endmodule

// File: tb/tb_csd_shift_add_mult.sv
// Scoreboard bench for csd_shift_add_mult with a 1-cycle-latency term memory model.
module tb_csd_shift_add_mult;

    localparam int DW = 8;
    localparam int KW = 4;
    localparam int NT = 16;
    localparam int PW = 25;

    typedef struct {
        logic [PW-1:0] prod;
        bit            err;
        int            cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic signed [DW-1:0] x = '0;
    logic        [4:0]    nTerms = '0;
    logic                 rdEn;
    logic        [3:0]    rdAddr;
    logic        [DW-1:0] rdDigit = '0;
    logic        [KW-1:0] rdK = '0;
    logic                 busy;
    logic                 done;
    logic signed [PW-1:0] product;
    logic                 err;

    logic [7:0] memD[NT];
    logic [3:0] memK[NT];
    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;

    csd_shift_add_mult #(
        .DW(DW),
        .KW(KW),
        .NT(NT),
        .PW(PW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .x      (x),
        .nTerms (nTerms),
        .rdEn   (rdEn),
        .rdAddr (rdAddr),
        .rdDigit(rdDigit),
        .rdK    (rdK),
        .busy   (busy),
        .done   (done),
        .product(product),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdEn) begin
            rdDigit <= memD[rdAddr];
            rdK     <= memK[rdAddr];
        end
    end

    function automatic exp_t model(input logic signed [7:0] xv, input int n);
        exp_t   r;
        longint a = 0;
        int     nn = (n > NT) ? NT : n;
        r.err = 1'b0;
        for (int i = 0; i < nn; i++) begin
            case (memD[i])
                8'h01:   a = a + longint'(xv) * (longint'(1) << memK[i]);
                8'hFF:   a = a - longint'(xv) * (longint'(1) << memK[i]);
                8'h00:   ;
                default: r.err = 1'b1;
            endcase
        end
        r.prod = a[PW-1:0];
        r.cyc  = 2 * nn + 1;
        return r;
    endfunction

    task automatic launch(input logic signed [7:0] xv, input int n);
        @(negedge clk);
        sb.push_back(model(xv, n));
        x      = xv;
        nTerms = n[4:0];
        start  = 1'b1;
    endtask

    task automatic wait_done(input int restart, output int cyc, output logic [PW-1:0] prod,
                             output logic e, output bit saw_rd, output bit busy_bad);
        cyc = -1; prod = '0; e = 1'b0; saw_rd = 1'b0; busy_bad = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = (c == restart);
            if (rdEn) saw_rd = 1'b1;
            if (done) begin
                cyc = c; prod = product; e = err;
                if (busy) busy_bad = 1'b1;
                break;
            end else if (!busy) begin
                busy_bad = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic set_mem(input int i, input logic [7:0] d, input logic [3:0] k);
        memD[i] = d;
        memK[i] = k;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rdEn} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: busy/done/rdEn=%b required 000", {busy, done, rdEn});
        end
        checks++;
        if (rdAddr !== 4'd0) begin
            errors++; $display("FAIL reset_addr: got %0d required 0", rdAddr);
        end
        checks++;
        if (product !== '0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_data: product=%0d err=%b required 0/0", product, err);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic(input string tag);
        exp_t ex; int cyc; logic [PW-1:0] p; logic e; bit rd, bb;
        set_mem(0, 8'h01, 4'd3);
        set_mem(1, 8'hFF, 4'd0);
        launch(8'sd5, 2);
        wait_done(0, cyc, p, e, rd, bb);
        ex = sb.pop_front();
        checks++;
        if (p !== ex.prod) begin
            errors++; $display("FAIL %s_product: got %0d required %0d", tag, $signed(p), $signed(ex.prod));
        end
        checks++;
        if (e !== ex.err) begin
            errors++; $display("FAIL %s_err: got %b required %b", tag, e, ex.err);
        end
        checks++;
        if (cyc !== ex.cyc) begin
            errors++; $display("FAIL %s_done_cycle: got %0d required %0d", tag, cyc, ex.cyc);
        end
        checks++;
        if (bb !== 1'b0 || rd !== 1'b1) begin
            errors++; $display("FAIL %s_busy_rden: busy_bad=%b saw_rdEn=%b required 0/1", tag, bb, rd);
        end
    endtask

    task automatic test_min_operand;
        exp_t ex; int cyc; logic [PW-1:0] p; logic e; bit rd, bb;
        set_mem(0, 8'h01, 4'd15);
        launch(-8'sd128, 1);
        wait_done(0, cyc, p, e, rd, bb);
        ex = sb.pop_front();
        checks++;
        if (p !== ex.prod || p !== 25'h1C00000) begin
            errors++; $display("FAIL minx_product: got %0d required %0d", $signed(p), $signed(ex.prod));
        end
        checks++;
        if (cyc !== ex.cyc) begin
            errors++; $display("FAIL minx_done_cycle: got %0d required %0d", cyc, ex.cyc);
        end
    endtask

    task automatic test_zero_terms;
        exp_t ex; int cyc; logic [PW-1:0] p; logic e; bit rd, bb;
        launch(8'sd77, 0);
        wait_done(0, cyc, p, e, rd, bb);
        ex = sb.pop_front();
        checks++;
        if (p !== ex.prod) begin
            errors++; $display("FAIL zero_product: got %0d required %0d", $signed(p), $signed(ex.prod));
        end
        checks++;
        if (cyc !== 1) begin
            errors++; $display("FAIL zero_done_cycle: got %0d required 1", cyc);
        end
        checks++;
        if (rd !== 1'b0) begin
            errors++; $display("FAIL zero_rden: saw rdEn=%b required 0", rd);
        end
    endtask

    task automatic test_illegal;
        exp_t ex; int cyc; logic [PW-1:0] p; logic e; bit rd, bb;
        set_mem(0, 8'h02, 4'd1);
        set_mem(1, 8'h01, 4'd2);
        launch(8'sd3, 2);
        wait_done(0, cyc, p, e, rd, bb);
        ex = sb.pop_front();
        checks++;
        if (p !== ex.prod) begin
            errors++; $display("FAIL illegal_product: got %0d required %0d", $signed(p), $signed(ex.prod));
        end
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL illegal_err: got %b required 1", e);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || product !== ex.prod) begin
            errors++; $display("FAIL illegal_sticky: err=%b product=%0d required 1/%0d", err, product, $signed(ex.prod));
        end
    endtask

    task automatic test_ignored_start;
        exp_t ex; int cyc; logic [PW-1:0] p; logic e; bit rd, bb;
        set_mem(0, 8'h01, 4'd4);
        set_mem(1, 8'hFF, 4'd2);
        set_mem(2, 8'h01, 4'd0);
        launch(8'sd7, 3);
        wait_done(2, cyc, p, e, rd, bb);
        ex = sb.pop_front();
        checks++;
        if (p !== ex.prod) begin
            errors++; $display("FAIL restart_product: got %0d required %0d", $signed(p), $signed(ex.prod));
        end
        checks++;
        if (cyc !== 7) begin
            errors++; $display("FAIL restart_done_cycle: got %0d required 7", cyc);
        end
    endtask

    task automatic test_reset_mid;
        exp_t ex; int cyc; logic [PW-1:0] p; logic e; bit rd, bb; bit saw_done;
        for (int i = 0; i < 4; i++) set_mem(i, (i % 2 == 0) ? 8'h01 : 8'hFF, 4'(i + 1));
        launch(-8'sd9, 4);
        saw_done = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) saw_done = 1'b1;
            if (c == 3) reset = 1'b0;
        end
        void'(sb.pop_front());
        checks++;
        if (busy !== 1'b0 || rdEn !== 1'b0 || product !== '0) begin
            errors++; $display("FAIL midreset_state: busy=%b rdEn=%b product=%0d required 0/0/0", busy, rdEn, product);
        end
        checks++;
        if (saw_done !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_done: saw done=%b required 0", saw_done | done);
        end
        reset = 1'b1;
        launch(-8'sd9, 4);
        wait_done(0, cyc, p, e, rd, bb);
        ex = sb.pop_front();
        checks++;
        if (p !== ex.prod || cyc !== ex.cyc) begin
            errors++; $display("FAIL midreset_rerun: product=%0d cycle=%0d required %0d/%0d", $signed(p), cyc, $signed(ex.prod), ex.cyc);
        end
    endtask

    task automatic test_clamp;
        exp_t ex; int cyc; logic [PW-1:0] p; logic e; bit rd, bb;
        for (int i = 0; i < NT; i++)
            set_mem(i, (i % 3 == 0) ? 8'h01 : ((i % 3 == 1) ? 8'hFF : 8'h00), 4'(i));
        launch(-8'sd3, 20);
        wait_done(0, cyc, p, e, rd, bb);
        ex = sb.pop_front();
        checks++;
        if (p !== ex.prod || e !== 1'b0) begin
            errors++; $display("FAIL clamp_product: got %0d err=%b required %0d err=0", $signed(p), e, $signed(ex.prod));
        end
        checks++;
        if (cyc !== 33) begin
            errors++; $display("FAIL clamp_done_cycle: got %0d required 33", cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < NT; i++) set_mem(i, 8'h00, 4'd0);
        test_reset();
        test_basic("basic");
        test_min_operand();
        test_zero_terms();
        test_illegal();
        test_basic("back_to_back");
        test_ignored_start();
        test_reset_mid();
        test_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
